truth_table_sweeper: RTL and testbench

//  Programmable multi-function truth-table engine, and successor to the fixed

---
 rtl/tt_pkg.sv | 23 ++
 rtl/tt_mask_bank.sv | 50 +++++
 rtl/truth_table_sweeper.sv | 151 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// tt_pkg: shared types and helpers for the truth-table sweeper.
//   tt_state_e        : sweep FSM states (idle, sweeping rows, done pulse)
//   NVARS_MIN/MAX     : legal range of input-variable count
//   NFUNC_MIN/MAX     : legal range of parallel function count
//   tt_rows()         : number of truth-table rows for a variable count
package tt_pkg;

  typedef enum logic [1:0] {
    TT_IDLE,
    TT_SWEEP,
    TT_DONE
  } tt_state_e;

  localparam int NVARS_MIN = 2;
  localparam int NVARS_MAX = 6;
  localparam int NFUNC_MIN = 1;
  localparam int NFUNC_MAX = 8;

  function automatic int tt_rows(input int nvars);
    return 1 << nvars;
  endfunction

endpackage

// File: rtl/tt_mask_bank.sv
// tt_mask_bank: NFUNC x 2^NVARS register file holding one row mask per
// function. Masks reset to all ones (constant-1 functions).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   we       : write enable (caller gates it to idle only)
//   func     : function index to write; indexes >= NFUNC are ignored
//   wdata    : new row mask, bit i = F(row i)
//   idx      : row index for the column read
//   col      : bit k = mask[k][idx], with the pending write forwarded
module tt_mask_bank
  import tt_pkg::*;
#(
  parameter int NVARS = 4,
  parameter int NFUNC = 5,
  parameter int FW    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [FW-1:0]              func,
  input  logic [(1 << NVARS)-1:0]    wdata,
  input  logic [NVARS-1:0]           idx,
  output logic [NFUNC-1:0]           col
);

  localparam int ROWS = tt_rows(NVARS);

  logic [ROWS-1:0] mask [NFUNC];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NFUNC; k++) mask[k] <= '1;
    end else if (we) begin
      for (int k = 0; k < NFUNC; k++) begin
        if (func == FW'(k)) mask[k] <= wdata;
      end
    end
  end

  // The write is forwarded into the read so a start issued together with a
  // write sees the new mask on its very first row.
  always_comb begin
    col = '0;
    for (int k = 0; k < NFUNC; k++) begin
      if (we && func == FW'(k)) col[k] = wdata[idx];
      else                      col[k] = mask[k][idx];
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: programmable multi-function truth-table engine.
// Holds NFUNC masks of 2^NVARS bits; on start it presents every row in
// ascending order under a valid/ready handshake, then pulses done.
// Optional feature macro: TT_ZERO_COUNT_EN adds per-function maxterm counters
// and the zero_cnt port.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   cfg_we     : write cfg_mask into function cfg_func (idle only)
//   cfg_func   : function index to write
//   cfg_mask   : row mask, bit i = F(row i)
//   start      : begin a sweep (idle only)
//   busy       : high while sweeping and during the done cycle
//   row_valid  : row_in/row_f valid
//   row_ready  : sink accepts the current row
//   row_in     : current input combination (MSB = first variable)
//   row_f      : bit k = function k at row_in
//   done       : one-cycle pulse after the last row is accepted
//   zero_cnt   : per-function maxterm counts, NVARS+1 bits each (macro only)
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int NVARS = 4,
  parameter int NFUNC = 5
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_we,
  input  logic [(NFUNC > 1 ? $clog2(NFUNC) : 1)-1:0] cfg_func,
  input  logic [(1 << NVARS)-1:0]                cfg_mask,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   row_valid,
  input  logic                                   row_ready,
  output logic [NVARS-1:0]                       row_in,
  output logic [NFUNC-1:0]                       row_f,
  output logic                                   done
`ifdef TT_ZERO_COUNT_EN
  ,
  output logic [NFUNC*(NVARS+1)-1:0]             zero_cnt
`endif
);

  localparam int ROWS = tt_rows(NVARS);
  localparam int FW   = (NFUNC > 1) ? $clog2(NFUNC) : 1;
  localparam int CW   = NVARS + 1;

  if (NVARS < NVARS_MIN || NVARS > NVARS_MAX || NFUNC < NFUNC_MIN || NFUNC > NFUNC_MAX) begin : g_param_check
    $error("truth_table_sweeper: NVARS or NFUNC out of range");
  end

  tt_state_e         state;
  logic [CW-1:0]     counter;
  logic [CW-1:0]     counter_next;
  logic              last_row;
  logic              accept;
  logic              bank_we;
  logic [NVARS-1:0]  rd_idx;
  logic [NFUNC-1:0]  col;

  // The counter is one bit wider than the row index, so the last row is
  // detected by value rather than by wrap-around.
  assign counter_next = counter + 1'b1;
  assign last_row     = (counter == CW'(ROWS - 1));
  assign accept       = (state == TT_SWEEP) && row_valid && row_ready;
  assign bank_we      = cfg_we && (state == TT_IDLE);
  // Idle reads row 0 for the first registered row; sweeping reads ahead.
  assign rd_idx       = (state == TT_SWEEP) ? counter_next[NVARS-1:0] : '0;

  tt_mask_bank #(
    .NVARS (NVARS),
    .NFUNC (NFUNC),
    .FW    (FW)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we),
    .func  (cfg_func),
    .wdata (cfg_mask),
    .idx   (rd_idx),
    .col   (col)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TT_IDLE;
      counter   <= '0;
      busy      <= 1'b0;
      row_valid <= 1'b0;
      done      <= 1'b0;
      row_in    <= '0;
      row_f     <= '0;
    end else begin
      case (state)
        TT_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= TT_SWEEP;
            counter   <= '0;
            busy      <= 1'b1;
            row_valid <= 1'b1;
            row_in    <= '0;
            row_f     <= col;
          end
        end
        TT_SWEEP: begin
          // With ready low nothing changes, so the row is held exactly.
          if (accept) begin
            if (last_row) begin
              state     <= TT_DONE;
              row_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              counter <= counter_next;
              row_in  <= counter_next[NVARS-1:0];
              row_f   <= col;
            end
          end
        end
        TT_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= TT_IDLE;
        end
        default: state <= TT_IDLE;
      endcase
    end
  end

`ifdef TT_ZERO_COUNT_EN
  logic [CW-1:0] zc [NFUNC];

  // Counters clear on an accepted start and then count every accepted row
  // whose function value is 0; they hold from done until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NFUNC; k++) zc[k] <= '0;
    end else if (state == TT_IDLE && start) begin
      for (int k = 0; k < NFUNC; k++) zc[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < NFUNC; k++) begin
        if (!row_f[k]) zc[k] <= zc[k] + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NFUNC; k++) begin : g_zc
    assign zero_cnt[k*CW +: CW] = zc[k];
  end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboard bench for truth_table_sweeper with
// NVARS=3, NFUNC=3. Expected rows come from a mask model; a monitor pops and
// compares on every accepted row. Define TT_ZERO_COUNT_EN to also cover the
// maxterm counters.
module tb_truth_table_sweeper;

  localparam int NV = 3;
  localparam int NF = 3;
  localparam int RW = 8;

  typedef struct {
    logic [NV-1:0] r;
    logic [NF-1:0] f;
    bit            last;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          cfg_we;
  logic [1:0]    cfg_func;
  logic [RW-1:0] cfg_mask;
  logic          start;
  logic          busy;
  logic          row_valid;
  logic          row_ready;
  logic [NV-1:0] row_in;
  logic [NF-1:0] row_f;
  logic          done;
`ifdef TT_ZERO_COUNT_EN
  logic [NF*(NV+1)-1:0] zero_cnt;
`endif

  int   checks = 0;
  int   failures = 0;
  int   done_seen = 0;
  bit   expect_done = 0;
  exp_t exp_q[$];
  logic [RW-1:0] model_mask [NF];
  int   exp_zero [NF];

  truth_table_sweeper #(.NVARS(NV), .NFUNC(NF)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_func  (cfg_func),
    .cfg_mask  (cfg_mask),
    .start     (start),
    .busy      (busy),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_in    (row_in),
    .row_f     (row_f),
    .done      (done)
`ifdef TT_ZERO_COUNT_EN
    ,
    .zero_cnt  (zero_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on accepted rows, checks the done pulse
  // timing and that a stalled row holds steady.
  initial begin
    exp_t          e;
    bit            held = 0;
    logic [NV-1:0] held_in;
    logic [NF-1:0] held_f;
    forever begin
      @(negedge clk);
      if (rst) begin
        expect_done = 0;
        held = 0;
      end else begin
        if (expect_done || done) checkOutput("done_pulse", done, expect_done);
        if (done) begin
          done_seen++;
`ifdef TT_ZERO_COUNT_EN
          for (int k = 0; k < NF; k++)
            checkOutput($sformatf("zero_cnt_f%0d", k), zero_cnt[k*(NV+1) +: (NV+1)], exp_zero[k]);
`endif
        end
        expect_done = 0;
        if (held) begin
          checkOutput("stall_valid", row_valid, 1);
          checkOutput("stall_row_in", row_in, held_in);
          checkOutput("stall_row_f", row_f, held_f);
        end
        held = row_valid && !row_ready;
        held_in = row_in;
        held_f = row_f;
        if (row_valid && row_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_row", 1, 0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("row_in", row_in, e.r);
            checkOutput("row_f", row_f, e.f);
            if (e.last) expect_done = 1;
          end
        end
      end
    end
  end

  // One cycle of configuration input; the model follows only when idle.
  task automatic applyStimulus(input logic [1:0] f, input logic [RW-1:0] m);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_func = f; cfg_mask = m;
    if (f < NF) model_mask[f] = m;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic pushExpected();
    exp_t e;
    for (int k = 0; k < NF; k++) exp_zero[k] = 0;
    for (int r = 0; r < RW; r++) begin
      e.r = NV'(r);
      for (int k = 0; k < NF; k++) begin
        e.f[k] = model_mask[k][r];
        if (!model_mask[k][r]) exp_zero[k]++;
      end
      e.last = (r == RW - 1);
      exp_q.push_back(e);
    end
  endtask

  function automatic logic readyFor(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 4 == 0) || (cyc % 4 == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  // mode: 0 ready always, 1 pattern 1,0,0,1, 2 random.
  // with_we: write (wf, wm) in the start cycle; inject: write+start mid-sweep.
  task automatic runSweep(input int mode, input bit with_we, input logic [1:0] wf,
                          input logic [RW-1:0] wm, input bit inject);
    int base;
    int cyc;
    @(posedge clk); #1;
    if (with_we) begin
      cfg_we = 1'b1; cfg_func = wf; cfg_mask = wm;
      if (wf < NF) model_mask[wf] = wm;
    end
    pushExpected();
    base = done_seen;
    start = 1'b1;
    row_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_we = 1'b0;
    checkOutput("busy_in_sweep", busy, 1);
    checkOutput("valid_after_start", row_valid, 1);
    cyc = 0;
    while (done_seen == base && cyc < 200) begin
      row_ready = readyFor(mode, cyc);
      if (inject && cyc == 3) begin
        cfg_we = 1'b1; cfg_func = 2'd0; cfg_mask = RW'($urandom); start = 1'b1;
      end
      if (inject && cyc == 4) begin
        cfg_we = 1'b0; start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    cfg_we = 1'b0;
    start = 1'b0;
    row_ready = 1'b0;
    checkOutput("sweep_done_seen", done_seen - base, 1);
    checkOutput("sweep_rows_left", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("single_done", done_seen - base, 1);
    checkOutput("idle_busy", busy, 0);
    exp_q.delete();
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_busy"}, busy, 0);
    checkOutput({name, "_valid"}, row_valid, 0);
    checkOutput({name, "_done"}, done, 0);
    checkOutput({name, "_row_in"}, row_in, 0);
    checkOutput({name, "_row_f"}, row_f, 0);
`ifdef TT_ZERO_COUNT_EN
    checkOutput({name, "_zero_cnt"}, zero_cnt, 0);
`endif
  endtask

  task automatic abortAtRow5();
    int base;
    int cyc;
    @(posedge clk); #1;
    pushExpected();
    base = done_seen;
    start = 1'b1;
    row_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(row_valid && row_in == 3'd5) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("reached_row5", row_in, 5);
    #1;
    rst = 1'b1;
    #1;
    checkAllZero("async_reset");
    exp_q.delete();
    for (int k = 0; k < NF; k++) model_mask[k] = '1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    row_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort_no_done", done_seen - base, 0);
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_func = '0; cfg_mask = '0;
    start = 1'b0; row_ready = 1'b0;
    for (int k = 0; k < NF; k++) model_mask[k] = '1;
    #2 rst = 1'b1;
    #1;
    checkAllZero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] default masks after reset");
    runSweep(0, 0, 2'd0, '0, 0);

    $display("[TB] directed masks, ready held high");
    applyStimulus(2'd0, 8'b1010_0110);
    applyStimulus(2'd1, 8'b1001_1010);
    applyStimulus(2'd3, 8'h00);
    runSweep(0, 0, 2'd0, '0, 0);

    $display("[TB] ready pattern 1,0,0,1");
    runSweep(1, 0, 2'd0, '0, 0);

    $display("[TB] write and start in the same cycle");
    runSweep(0, 1, 2'd2, 8'b0111_1110, 0);

    $display("[TB] config and start ignored mid-sweep");
    runSweep(1, 0, 2'd0, '0, 1);

    $display("[TB] reset at row 5");
    abortAtRow5();
    runSweep(0, 0, 2'd0, '0, 0);

    $display("[TB] randomized sweeps");
    for (int n = 0; n < 6; n++) begin
      for (int w = 0; w < 3; w++)
        applyStimulus(2'($urandom_range(0, 3)), RW'($urandom));
      runSweep(2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), RW'($urandom),
               1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
